// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
//   Sequencer between the A/B block-read operand memories and an N x N
//   output-stationary systolic array. A multiply runs
//     IDLE -> CLEAR (1) -> FEED (N) -> FLUSH (2N-1) -> DONE (1) -> IDLE
//   FEED step k reads block k (address k*N) from both memories; each lane
//   then passes through a skew line of lane+1 registers so operand pairs
//   meet on the array diagonals. In IDLE and DONE the host write path is
//   routed combinationally to the selected memory.
//
// Handshake: there is no valid/ready pair. `start` is a level sampled
//   only in IDLE (ignored elsewhere, never queued); `done` is a one-cycle
//   pulse in DONE; a host write is accepted in the cycle it is presented
//   if the block is idle and the address is in range, otherwise it is
//   dropped and `host_err` pulses the following cycle.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start / busy / done : multiply request and status
//   host_*              : host write request (sel 0 = A, 1 = B), host_err
//   a_* / b_*           : operand memory write/read ports
//   array_clr           : accumulator clear to the array
//   feed_valid          : array accumulates while high
//   a_feed / b_feed     : skewed west / north edge operands
//   dbg_state           : FSM state (0 IDLE, 1 CLEAR, 2 FEED, 3 FLUSH, 4 DONE)
module systolic_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int N = 3,
  localparam int ADDR_W = $clog2(N*N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    host_wr_en,
  input  logic                    host_sel,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [DATA_WIDTH-1:0]   host_data,
  output logic                    host_err,
  output logic                    a_wr_en,
  output logic                    b_wr_en,
  output logic                    a_rd_en,
  output logic                    b_rd_en,
  output logic [ADDR_W-1:0]       a_addr,
  output logic [ADDR_W-1:0]       b_addr,
  output logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [N*DATA_WIDTH-1:0] a_rdata,
  input  logic [N*DATA_WIDTH-1:0] b_rdata,
  output logic                    array_clr,
  output logic                    feed_valid,
  output logic [N*DATA_WIDTH-1:0] a_feed,
  output logic [N*DATA_WIDTH-1:0] b_feed,
  output logic [2:0]              dbg_state
);

  localparam int CNT_W = $clog2(2*N);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(N*N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               feed_valid_d;
  logic               host_err_d;
  logic               addr_ok;
  logic               feeding;
  logic [ADDR_W-1:0]  feed_addr;

  assign dbg_state = state;
  assign feeding   = (state == S_FEED);
  assign addr_ok   = ({1'b0, host_addr} < DEPTH);
  assign feed_addr = ADDR_W'(32'(cnt) * N);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      feed_valid <= 1'b0;
      host_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      feed_valid <= feed_valid_d;
      host_err   <= host_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    feed_valid_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        // valid rises the cycle after the first FEED cycle (registered)
        feed_valid_d = 1'b1;
        if (cnt == CNT_W'(N-1)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt == CNT_W'(2*N-2)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          feed_valid_d = 1'b1;
          cnt_d        = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state == S_CLEAR) || (state == S_FEED) || (state == S_FLUSH);
    done      = (state == S_DONE);
    array_clr = (state == S_CLEAR);
  end

  // Host writes are dropped while a multiply owns the memories or when
  // the address lies past the last word.
  assign host_err_d = host_wr_en && (busy || !addr_ok);

  // Memory port mux; everything is held at 0 while reset is asserted.
  always_comb begin
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    a_rd_en = 1'b0;
    b_rd_en = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    a_wdata = '0;
    b_wdata = '0;
    if (!reset) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (!host_sel) begin
            a_wr_en = host_wr_en && addr_ok;
            a_addr  = host_addr;
            a_wdata = host_data;
          end else begin
            b_wr_en = host_wr_en && addr_ok;
            b_addr  = host_addr;
            b_wdata = host_data;
          end
        end
        S_FEED: begin
          a_rd_en = 1'b1;
          b_rd_en = 1'b1;
          a_addr  = feed_addr;
          b_addr  = feed_addr;
        end
        default: ;
      endcase
    end
  end

  // Skew lines: lane i has i+1 stages, loaded with zeros outside FEED so
  // FLUSH drains them.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_sr [0:i];
    logic [DATA_WIDTH-1:0] b_sr [0:i];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else begin
        a_sr[0] <= feeding ? a_rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_sr[0] <= feeding ? b_rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign a_feed[i*DATA_WIDTH +: DATA_WIDTH] = a_sr[i];
    assign b_feed[i*DATA_WIDTH +: DATA_WIDTH] = b_sr[i];
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl (N=3, DATA_WIDTH=8). The operand memories
// are modelled here (falling-edge write, asynchronous block read) and are
// loaded only through the DUT host path. Expected outputs per cycle come
// from the timing rules: cycle c after start -> CLEAR at 1, FEED k at 2+k,
// lane i carries A[i][k] at 3+k+i, valid 3..3N, done at 3N+1.
module tb_systolic_feed_ctrl;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = $clog2(N*N);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done;
  logic          host_wr_en, host_sel;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_err;
  logic          a_wr_en, b_wr_en, a_rd_en, b_rd_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [N*DW-1:0] a_rdata, b_rdata;
  logic          array_clr, feed_valid;
  logic [N*DW-1:0] a_feed, b_feed;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_a [N*N];
  logic [DW-1:0] mem_b [N*N];
  logic [DW-1:0] ma [N][N];   // ma[i][k] = A[i][k]
  logic [DW-1:0] mb [N][N];   // mb[k][j] = B[k][j]

  systolic_feed_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .host_wr_en(host_wr_en), .host_sel(host_sel), .host_addr(host_addr),
    .host_data(host_data), .host_err(host_err),
    .a_wr_en(a_wr_en), .b_wr_en(b_wr_en), .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .array_clr(array_clr),
    .feed_valid(feed_valid), .a_feed(a_feed), .b_feed(b_feed),
    .dbg_state(dbg_state)
  );

  // clock / memories
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_wr_en && int'(a_addr) < N*N) mem_a[a_addr] <= a_wdata;
    if (b_wr_en && int'(b_addr) < N*N) mem_b[b_addr] <= b_wdata;
  end

  always_comb begin
    a_rdata = '0;
    b_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(a_addr) + i < N*N) a_rdata[i*DW +: DW] = mem_a[int'(a_addr) + i];
      if (int'(b_addr) + i < N*N) b_rdata[i*DW +: DW] = mem_b[int'(b_addr) + i];
    end
  end

  // helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_feed(input int c, input bit is_b);
    logic [31:0] v;
    v = '0;
    for (int l = 0; l < N; l++) begin
      int k;
      k = c - 3 - l;
      if (k >= 0 && k < N) v[l*DW +: DW] = is_b ? mb[k][l] : ma[l][k];
    end
    return v;
  endfunction

  // All outputs for cycle c of a run; c outside 0..3N+2 means idle.
  task automatic check_cycle(input int c, input bit exp_err);
    bit rd;
    int ad;
    rd = (c >= 2 && c <= N + 1);
    ad = rd ? (c - 2) * N : 0;
    check($sformatf("c%0d_busy", c), 32'(busy), 32'(c >= 1 && c <= 3*N));
    check($sformatf("c%0d_done", c), 32'(done), 32'(c == 3*N + 1));
    check($sformatf("c%0d_clr", c), 32'(array_clr), 32'(c == 1));
    check($sformatf("c%0d_valid", c), 32'(feed_valid), 32'(c >= 3 && c <= 3*N));
    check($sformatf("c%0d_rd", c), 32'({a_rd_en, b_rd_en}), rd ? 32'd3 : 32'd0);
    check($sformatf("c%0d_wr", c), 32'({a_wr_en, b_wr_en}), 32'd0);
    check($sformatf("c%0d_a_addr", c), 32'(a_addr), 32'(ad));
    check($sformatf("c%0d_b_addr", c), 32'(b_addr), 32'(ad));
    check($sformatf("c%0d_a_feed", c), 32'(a_feed), exp_feed(c, 1'b0));
    check($sformatf("c%0d_b_feed", c), 32'(b_feed), exp_feed(c, 1'b1));
    check($sformatf("c%0d_err", c), 32'(host_err), 32'(exp_err));
  endtask

  task automatic clear_host();
    host_wr_en = 1'b0;
    host_sel   = 1'b0;
    host_addr  = '0;
    host_data  = '0;
  endtask

  task automatic host_write(input bit sel, input int addr, input logic [DW-1:0] data);
    tick();
    host_wr_en = 1'b1;
    host_sel   = sel;
    host_addr  = AW'(addr);
    host_data  = data;
    #3;
    check($sformatf("hw_en_%0d_%0d", sel, addr), 32'({a_wr_en, b_wr_en}), sel ? 32'd1 : 32'd2);
    check($sformatf("hw_addr_%0d_%0d", sel, addr), 32'(sel ? b_addr : a_addr), 32'(addr));
    tick();
    clear_host();
    #3;
    check($sformatf("hw_err_%0d_%0d", sel, addr), 32'(host_err), 32'd0);
    check($sformatf("hw_mem_%0d_%0d", sel, addr), 32'(sel ? mem_b[addr] : mem_a[addr]), 32'(data));
  endtask

  task automatic load_mems();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) host_write(1'b0, k*N + i, ma[i][k]);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) host_write(1'b1, k*N + j, mb[k][j]);
  endtask

  // One multiply, cycles 0..3N+1; the caller's next tick is cycle 3N+2.
  // inj adds start pulses at 3 and 3N+1 and a blocked B write at 5.
  task automatic run_mult(input bit inj);
    tick();
    start = 1'b1;
    #3;
    check_cycle(0, 1'b0);
    for (int c = 1; c <= 3*N + 1; c++) begin
      tick();
      start = inj && (c == 3 || c == 3*N + 1);
      if (inj && c == 5) begin
        host_wr_en = 1'b1;
        host_sel   = 1'b1;
        host_addr  = AW'(4);
        host_data  = 8'hAA;
      end else begin
        clear_host();
      end
      #3;
      check_cycle(c, inj && c == 6);
    end
    start = 1'b0;
    clear_host();
  endtask

  task automatic set_directed();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = DW'(8'h10 * i + k);
        mb[i][k] = DW'(8'h40 + 8'h10 * i + k);
      end
  endtask

  initial begin
    // reset: outputs quiet even with a host write pending
    reset      = 1'b1;
    start      = 1'b0;
    host_wr_en = 1'b1;
    host_sel   = 1'b0;
    host_addr  = AW'(2);
    host_data  = 8'h5A;
    for (int r = 0; r < 2; r++) begin
      tick();
      #3;
      check($sformatf("rst%0d_en", r), 32'({a_wr_en, b_wr_en, a_rd_en, b_rd_en}), 32'd0);
    end
    tick();
    reset = 1'b0;
    clear_host();
    #3;
    check_cycle(-100, 1'b0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // address range: 5 lands, 9 blocked with one-cycle err pulse
    host_write(1'b0, 5, 8'h77);
    tick();
    host_wr_en = 1'b1;
    host_sel   = 1'b1;
    host_addr  = AW'(9);
    host_data  = 8'h33;
    #3;
    check("oor_wr_en", 32'({a_wr_en, b_wr_en}), 32'd0);
    tick();
    clear_host();
    #3;
    check("oor_err", 32'(host_err), 32'd1);
    tick();
    #3;
    check("oor_err_drop", 32'(host_err), 32'd0);

    // directed skew sequence
    set_directed();
    load_mems();
    run_mult(1'b0);

    // start while busy + blocked host write, then back-to-back restart
    run_mult(1'b1);
    run_mult(1'b0);
    check("blocked_mem_b4", 32'(mem_b[4]), 32'(mb[1][1]));

    // reset mid-FEED abandons the run
    tick();
    start = 1'b1;
    #3;
    check_cycle(0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
      #3;
      check_cycle(c, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #3;
    check_cycle(-100, 1'b0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    for (int c = 5; c <= 12; c++) begin
      tick();
      #3;
      check($sformatf("mid_rst_c%0d_done", c), 32'(done), 32'd0);
      check($sformatf("mid_rst_c%0d_busy", c), 32'(busy), 32'd0);
    end
    run_mult(1'b0);

    // random operands
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          ma[i][k] = DW'($urandom_range(0, 255));
          mb[i][k] = DW'($urandom_range(0, 255));
        end
      load_mems();
      run_mult(r == 1);
      run_mult(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
